// File: rtl/imem_prog_arbiter_if.sv
// Bus bundle between the instruction-memory arbiter, fetch, the UART
// programmer and the instruction BRAM.
// The arbiter is on the slave side; fetch, programmer and BRAM are on the master side.
// IMEM_ARB_READBACK_EN adds the prog_rdata return path.
interface imem_prog_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // Fetch side
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_rdata;
  logic              fetch_valid;

  // Programmer side
  logic              prog_req;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_wdata;
  logic              prog_ack;
  logic [15:0]       prog_words;
`ifdef IMEM_ARB_READBACK_EN
  logic [DATA_W-1:0] prog_rdata;
`endif

  // Core control
  logic              core_stall;
  logic              core_flush;

  // BRAM port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr,
    input  prog_req, prog_we, prog_addr, prog_wdata,
    input  mem_rdata,
`ifdef IMEM_ARB_READBACK_EN
    output prog_rdata,
`endif
    output fetch_rdata, fetch_valid,
    output prog_ack, prog_words,
    output core_stall, core_flush,
    output mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr,
    output prog_req, prog_we, prog_addr, prog_wdata,
    output mem_rdata,
`ifdef IMEM_ARB_READBACK_EN
    input  prog_rdata,
`endif
    input  fetch_rdata, fetch_valid,
    input  prog_ack, prog_words,
    input  core_stall, core_flush,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_prog_arbiter.sv
// Arbiter and sequencer for the single-port instruction BRAM.
// The UART programmer has priority over fetch.
// The core is stalled while the programmer owns the port. On release the
// core is held for HOLD_CYCLES more cycles, and then core_flush pulses once.
// Optional feature: define IMEM_ARB_READBACK_EN to let the programmer read
// words back. A PROG cycle with prog_we=0 then becomes a read, returned on
// prog_rdata alongside prog_ack.
module imem_prog_arbiter #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 2   // 0..15
) (
  input logic                 clk,
  input logic                 Rst,
  imem_prog_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {RUN, QUIESCE, PROG, RELEASE} state_e;

  localparam logic [3:0] HoldInit = 4'(HOLD_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  hold_q, hold_d;
  logic [15:0] words_q, words_d;
  logic        fetch_valid_q;
  logic        ack_q;
  logic        stall_q;
  logic        flush_q;

  logic              prog_write;
  logic              prog_read;
  logic              mem_en_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;

  assign prog_write = (state_q == PROG) && bus.prog_req && bus.prog_we;

`ifdef IMEM_ARB_READBACK_EN
  assign prog_read      = (state_q == PROG) && bus.prog_req && !bus.prog_we;
  assign bus.prog_rdata = bus.mem_rdata;
`else
  assign prog_read      = 1'b0;
`endif

  // Next-state, hold-counter and word-count logic
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    hold_d  = hold_q;
    words_d = words_q;
    case (state_q)
      RUN: begin
        if (bus.prog_req) state_d = QUIESCE;
      end
      QUIESCE: begin
        // One dead cycle lets a read issued in the last RUN cycle return.
        state_d = PROG;
        words_d = '0;
      end
      PROG: begin
        if (!bus.prog_req) begin
          state_d = RELEASE;
          hold_d  = HoldInit;
        end else if (prog_write && (words_q != 16'hFFFF)) begin
          words_d = words_q + 16'd1;
        end
      end
      RELEASE: begin
        // core_flush is registered, so it is already high in the final
        // RELEASE cycle. A request arriving in that cycle is taken through
        // RUN/QUIESCE, so the flush already on the bus is honoured.
        if (hold_q == 4'd0) begin
          state_d = RUN;
        end else if (bus.prog_req) begin
          state_d = PROG;
          words_d = '0;
        end else begin
          hold_d = hold_q - 4'd1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // BRAM port mux: fetch owns the port in RUN, the programmer owns it in PROG
  always_comb begin
    mem_en_d   = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = bus.fetch_addr;
    case (state_q)
      RUN: mem_en_d = bus.fetch_req;
      PROG: begin
        if (prog_write || prog_read) begin
          mem_en_d   = 1'b1;
          mem_we_d   = prog_write;
          mem_addr_d = bus.prog_addr;
        end
      end
      default: mem_en_d = 1'b0;
    endcase
  end

  assign bus.mem_en    = mem_en_d;
  assign bus.mem_we    = mem_we_d;
  assign bus.mem_addr  = mem_addr_d;
  assign bus.mem_wdata = prog_write ? bus.prog_wdata : {DATA_W{1'b0}};

  // State register plus registered handshake and core-control outputs
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q       <= RUN;
      hold_q        <= 4'd0;
      words_q       <= 16'd0;
      fetch_valid_q <= 1'b0;
      ack_q         <= 1'b0;
      stall_q       <= 1'b0;
      flush_q       <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      state_q       <= state_d;
      hold_q        <= hold_d;
      words_q       <= words_d;
      fetch_valid_q <= (state_q == RUN) && bus.fetch_req;
      ack_q         <= prog_write || prog_read;
      stall_q       <= (state_d != RUN);
      flush_q       <= (state_d == RELEASE) && (hold_d == 4'd0);
    end
  end

  assign bus.fetch_rdata = bus.mem_rdata;
  assign bus.fetch_valid = fetch_valid_q;
  assign bus.prog_ack    = ack_q;
  assign bus.prog_words  = words_q;
  assign bus.core_stall  = stall_q;
  assign bus.core_flush  = flush_q;

endmodule

// File: tb/tb_imem_prog_arbiter.sv
// Self-checking bench for imem_prog_arbiter.
// The bench runs directed sessions from the test plan, then random episodes.
// The stimulus side derives the expected outputs for the next cycle from the
// timing rules. A separate monitor compares those against the DUT one cycle
// later. Build with IMEM_ARB_READBACK_EN to also exercise programmer readback.
module tb_imem_prog_arbiter;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 32;
  localparam int HOLD        = 2;
  localparam int DEPTH       = 1 << ADDR_W;
  localparam int CYCLE_LIMIT = 20000;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic        fvalid;
    logic        ack;
    logic [15:0] words;
  } exp_t;

  typedef struct packed {
    logic              rd;
    logic [DATA_W-1:0] data;
  } ack_t;

  logic clk = 1'b0;
  logic Rst;
  always #5 clk = ~clk;

  imem_prog_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_prog_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .HOLD_CYCLES(HOLD)
  ) dut (
    .clk (clk),
    .Rst (Rst),
    .bus (bus)
  );

  function automatic logic [DATA_W-1:0] init_word(input int a);
    if (a == 4) return 32'h0050_0093;
    return DATA_W'(a * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Instruction BRAM: synchronous read with 1-cycle latency; contents loaded on the first edge
  logic [DATA_W-1:0] bram [0:DEPTH-1];
  logic [DATA_W-1:0] bram_q;
  logic              bram_loaded = 1'b0;
  always @(posedge clk) begin
    if (!bram_loaded) begin
      for (int i = 0; i < DEPTH; i++) bram[i] <= init_word(i);
      bram_loaded <= 1'b1;
    end else if (bus.mem_en) begin
      if (bus.mem_we) bram[bus.mem_addr] <= bus.mem_wdata;
      else            bram_q <= bram[bus.mem_addr];
    end
  end
  assign bus.mem_rdata = bram_q;

  // Reference state
  logic [DATA_W-1:0] shadow [0:DEPTH-1];
  logic [15:0]       exp_words;
  exp_t              exp_q[$];
  logic [DATA_W-1:0] fetch_q[$];
  ack_t              ack_q[$];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction
  function automatic logic [ADDR_W-1:0] raddr();
    return ADDR_W'($urandom_range(0, 31));
  endfunction
  function automatic logic [DATA_W-1:0] rdata();
    return DATA_W'($urandom);
  endfunction

  // Apply one cycle of inputs; e describes the outputs expected after the next edge
  task automatic step(input logic rst, input logic fr, input logic [ADDR_W-1:0] fa,
                      input logic pr, input logic pw, input logic [ADDR_W-1:0] pa,
                      input logic [DATA_W-1:0] pd, input exp_t e);
    @(negedge clk);
    Rst            = rst;
    bus.fetch_req  = fr;
    bus.fetch_addr = fa;
    bus.prog_req   = pr;
    bus.prog_we    = pw;
    bus.prog_addr  = pa;
    bus.prog_wdata = pd;
    exp_q.push_back(e);
  endtask

  task automatic rst_cycle();
    exp_t e;
    exp_words = 16'd0;
    e = '{stall: 1'b0, flush: 1'b0, fvalid: 1'b0, ack: 1'b0, words: 16'd0};
    step(1'b1, 1'b0, raddr(), 1'b0, 1'b0, raddr(), rdata(), e);
  endtask

  // RUN with the programmer idle: fetch is served with a 1-cycle latency; prog_we is ignored
  task automatic run_cycle(input logic fr, input logic [ADDR_W-1:0] fa);
    exp_t e;
    e = '{stall: 1'b0, flush: 1'b0, fvalid: fr, ack: 1'b0, words: exp_words};
    step(1'b0, fr, fa, 1'b0, rbit(), raddr(), rdata(), e);
    if (fr) fetch_q.push_back(shadow[fa]);
  endtask

  // RUN cycle in which prog_req rises: that cycle's fetch is still served; stall starts next
  task automatic start_cycle(input logic fr, input logic [ADDR_W-1:0] fa);
    exp_t e;
    e = '{stall: 1'b1, flush: 1'b0, fvalid: fr, ack: 1'b0, words: exp_words};
    step(1'b0, fr, fa, 1'b1, rbit(), raddr(), rdata(), e);
    if (fr) fetch_q.push_back(shadow[fa]);
  endtask

  // Quiesce cycle: the session word count reads 0 once PROG is entered
  task automatic quiesce_cycle();
    exp_t e;
    exp_words = 16'd0;
    e = '{stall: 1'b1, flush: 1'b0, fvalid: 1'b0, ack: 1'b0, words: 16'd0};
    step(1'b0, rbit(), raddr(), 1'b1, rbit(), raddr(), rdata(), e);
  endtask

  task automatic prog_cycle(input logic we, input logic [ADDR_W-1:0] pa, input logic [DATA_W-1:0] pd);
    exp_t e;
    ack_t a;
    logic ack_exp;
    ack_exp = 1'b0;
    a = '{rd: 1'b0, data: '0};
    if (we) begin
      shadow[pa] = pd;
      if (exp_words != 16'hFFFF) exp_words = exp_words + 16'd1;
      ack_exp = 1'b1;
    end else begin
`ifdef IMEM_ARB_READBACK_EN
      ack_exp = 1'b1;
      a = '{rd: 1'b1, data: shadow[pa]};
`endif
    end
    e = '{stall: 1'b1, flush: 1'b0, fvalid: 1'b0, ack: ack_exp, words: exp_words};
    step(1'b0, rbit(), raddr(), 1'b1, we, pa, pd, e);
    if (ack_exp) ack_q.push_back(a);
  endtask

  // Cycle in which prog_req falls: prog_we is held high and must be ignored
  task automatic drop_cycle();
    exp_t e;
    e = '{stall: 1'b1, flush: (HOLD == 0), fvalid: 1'b0, ack: 1'b0, words: exp_words};
    step(1'b0, rbit(), raddr(), 1'b0, 1'b1, raddr(), rdata(), e);
  endtask

  // k-th cycle after the drop (0..HOLD); flush lands on k == HOLD, and RUN follows
  task automatic release_cycle(input int k, input logic re);
    exp_t e;
    if (re) begin
      exp_words = 16'd0;
      e = '{stall: 1'b1, flush: 1'b0, fvalid: 1'b0, ack: 1'b0, words: 16'd0};
    end else begin
      e = '{stall: (k != HOLD), flush: (k + 1 == HOLD), fvalid: 1'b0, ack: 1'b0, words: exp_words};
    end
    step(1'b0, rbit(), raddr(), re, rbit(), raddr(), rdata(), e);
  endtask

  task automatic release_phase(input int reassert_at, output logic back_to_prog);
    drop_cycle();
    back_to_prog = 1'b0;
    for (int k = 0; k <= HOLD && !back_to_prog; k++) begin
      if (k == reassert_at && k < HOLD) begin
        release_cycle(k, 1'b1);
        back_to_prog = 1'b1;
      end else begin
        release_cycle(k, 1'b0);
      end
    end
  endtask

  task automatic episode();
    int   n;
    logic back;
    logic done;
    n = $urandom_range(1, 6);
    repeat (n) run_cycle(rbit(), raddr());
    start_cycle(rbit(), raddr());
    quiesce_cycle();
    done = 1'b0;
    while (!done) begin
      n = $urandom_range(0, 8);
      repeat (n) prog_cycle(rbit(), raddr(), rdata());
      if ($urandom_range(0, 7) == 0) begin
        rst_cycle();
        done = 1'b1;
      end else begin
        release_phase($urandom_range(0, 3 * HOLD + 2), back);
        done = !back;
      end
    end
  endtask

  // Monitor: one expectation per cycle, plus data queues popped on valid/ack
  initial begin
    exp_t              e;
    ack_t              a;
    logic [DATA_W-1:0] d;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("core_stall",  32'(bus.core_stall),  32'(e.stall));
        check("core_flush",  32'(bus.core_flush),  32'(e.flush));
        check("fetch_valid", 32'(bus.fetch_valid), 32'(e.fvalid));
        check("prog_ack",    32'(bus.prog_ack),    32'(e.ack));
        check("prog_words",  32'(bus.prog_words),  32'(e.words));
      end
      if (bus.fetch_valid === 1'b1) begin
        if (fetch_q.size() == 0) check("fetch_q_underflow", 32'(fetch_q.size()), 32'd1);
        else begin
          d = fetch_q.pop_front();
          check("fetch_rdata", 32'(bus.fetch_rdata), 32'(d));
        end
      end
      if (bus.prog_ack === 1'b1) begin
        if (ack_q.size() == 0) check("ack_q_underflow", 32'(ack_q.size()), 32'd1);
        else begin
          a = ack_q.pop_front();
`ifdef IMEM_ARB_READBACK_EN
          if (a.rd) check("prog_rdata", 32'(bus.prog_rdata), 32'(a.data));
`endif
        end
      end
    end
  end

  initial begin
    #(CYCLE_LIMIT * 10);
    $display("FAIL watchdog: run exceeded %0d cycles", CYCLE_LIMIT);
    $fatal(1, "watchdog");
  end

  initial begin
    logic back;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_word(i);
    exp_words      = 16'd0;
    Rst            = 1'b1;
    bus.fetch_req  = 1'b0;
    bus.fetch_addr = '0;
    bus.prog_req   = 1'b0;
    bus.prog_we    = 1'b0;
    bus.prog_addr  = '0;
    bus.prog_wdata = '0;

    repeat (3) rst_cycle();

    // Plain fetch of the preloaded word at 0x004
    run_cycle(1'b1, 12'h004);
    run_cycle(1'b0, 12'h000);
    run_cycle(1'b1, 12'h004);

    // prog_req with fetch_req in the same cycle, then 3 back-to-back writes
    start_cycle(1'b1, 12'h008);
    quiesce_cycle();
    prog_cycle(1'b1, 12'h000, 32'h1111_0001);
    prog_cycle(1'b1, 12'h001, 32'h2222_0002);
    prog_cycle(1'b1, 12'h002, 32'h3333_0003);
    release_phase(-1, back);
    run_cycle(1'b1, 12'h000);
    run_cycle(1'b1, 12'h001);
    run_cycle(1'b1, 12'h002);
    run_cycle(1'b0, 12'h000);

    // Request reasserted in the 2nd RELEASE cycle
    start_cycle(1'b0, 12'h000);
    quiesce_cycle();
    prog_cycle(1'b1, 12'h003, 32'h4444_0004);
    release_phase(1, back);
    prog_cycle(1'b1, 12'h005, 32'h5555_0005);
    release_phase(-1, back);
    run_cycle(1'b1, 12'h005);

    // Reset after 5 writes
    start_cycle(1'b0, 12'h000);
    quiesce_cycle();
    for (int i = 0; i < 5; i++) prog_cycle(1'b1, ADDR_W'(8 + i), DATA_W'(32'hC0DE_0000 + i));
    rst_cycle();
    run_cycle(1'b1, 12'h008);
    run_cycle(1'b1, 12'h00C);

    // Write then read back 0x001 (readback only acks when the feature is built in)
    start_cycle(1'b0, 12'h000);
    quiesce_cycle();
    prog_cycle(1'b1, 12'h001, 32'hBEEF_0001);
    prog_cycle(1'b0, 12'h001, 32'h0);
    prog_cycle(1'b0, 12'h004, 32'h0);
    release_phase(-1, back);
    run_cycle(1'b1, 12'h001);

    repeat (60) episode();

    repeat (3) run_cycle(1'b0, 12'h000);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    check("exp_q_drained",   32'(exp_q.size()),   32'd0);
    check("fetch_q_drained", 32'(fetch_q.size()), 32'd0);
    check("ack_q_drained",   32'(ack_q.size()),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
